serial_port_ctrl: RTL and testbench

- Buffers and sequences byte traffic between the processor's memory-mapped serial interface (data_memory serial pins) and the external UART link.
- Contains a TX FIFO, an RX FIFO and a TX pacing state machine that enforces a minimum inter-byte gap.
- Sits at the top level between processor (serial_in/serial_out/serial_rden_out/serial_wren_out/serial_ready_in/serial_valid_in) and the UART.
- Status and sticky error flags are exposed for debug.

---
 rtl/serial_port_ctrl.sv | 178 +++++++++++++++++
 tb/tb_serial_port_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_port_ctrl.sv
// Serial port controller: TX/RX byte FIFOs between the processor's memory-mapped
// serial pins and the UART link, with paced TX issue and sticky debug error flags.
module serial_port_ctrl #(
  parameter int TX_AW  = 4,
  parameter int RX_AW  = 4,
  parameter int TX_GAP = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [7:0]       cpu_tx_data,
  input  logic             cpu_tx_wren,
  output logic             cpu_tx_ready,
  input  logic             cpu_rx_rden,
  output logic [7:0]       cpu_rx_data,
  output logic             cpu_rx_valid,
  output logic [7:0]       uart_tx_data,
  output logic             uart_tx_valid,
  input  logic             uart_tx_ready,
  input  logic [7:0]       uart_rx_data,
  input  logic             uart_rx_valid,
  output logic             uart_rx_ready,
  input  logic             err_clear,
  output logic             tx_overflow,
  output logic             rx_underflow,
  output logic [TX_AW:0]   tx_count,
  output logic [RX_AW:0]   rx_count
);

  localparam int TX_DEPTH = 1 << TX_AW;
  localparam int RX_DEPTH = 1 << RX_AW;
  localparam int GW       = (TX_GAP > 1) ? $clog2(TX_GAP) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_t;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic             tx_full, tx_empty, tx_push, tx_pop;
  logic             tx_avail, tx_more;

  tx_state_t        tx_state;
  logic             tx_valid_q;
  logic [GW-1:0]    gap_cnt;

  assign tx_full  = (tx_count == (TX_AW+1)'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);
  assign tx_push  = cpu_tx_wren && !tx_full;
  assign tx_pop   = tx_valid_q && uart_tx_ready;
  // A byte pushed this cycle is visible to the FSM so valid rises one cycle after wren.
  assign tx_avail = !tx_empty || tx_push;
  // Occupancy after a pop in SEND is nonzero if more than one byte or a concurrent push.
  assign tx_more  = (tx_count != (TX_AW+1)'(1)) || tx_push;

  assign cpu_tx_ready  = !tx_full;
  assign uart_tx_valid = tx_valid_q;
  assign uart_tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];

  // NOTE: storage arrays carry no reset; occupancy and pointers define validity.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= cpu_tx_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + (TX_AW+1)'(1);
        2'b01:   tx_count <= tx_count - (TX_AW+1)'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // TX pacing FSM; uart_tx_valid is a registered copy of "in SEND".
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state   <= IDLE;
      tx_valid_q <= 1'b0;
      gap_cnt    <= '0;
    end else begin
      case (tx_state)
        IDLE: begin
          if (tx_avail) begin
            tx_state   <= SEND;
            tx_valid_q <= 1'b1;
          end
        end
        SEND: begin
          if (uart_tx_ready) begin
            if (TX_GAP > 0) begin
              tx_state   <= GAP;
              tx_valid_q <= 1'b0;
              gap_cnt    <= GW'(TX_GAP - 1);
            end else if (tx_more) begin
              tx_state   <= SEND;
              tx_valid_q <= 1'b1;
            end else begin
              tx_state   <= IDLE;
              tx_valid_q <= 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            tx_state   <= tx_avail ? SEND : IDLE;
            tx_valid_q <= tx_avail;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          tx_state   <= IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX FIFO
  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic             rx_full, rx_empty, rx_push, rx_pop;

  assign rx_full  = (rx_count == (RX_AW+1)'(RX_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign rx_push  = uart_rx_valid && !rx_full;
  assign rx_pop   = cpu_rx_rden && !rx_empty;

  assign uart_rx_ready = !rx_full;
  assign cpu_rx_valid  = !rx_empty;
  assign cpu_rx_data   = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

  always_ff @(posedge clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= uart_rx_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RX_AW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RX_AW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RX_AW+1)'(1);
        2'b01:   rx_count <= rx_count - (RX_AW+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // ------------------------------------------------------------ sticky flags
  // A new error wins over err_clear in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_overflow  <= 1'b0;
      rx_underflow <= 1'b0;
    end else begin
      if (cpu_tx_wren && tx_full) tx_overflow <= 1'b1;
      else if (err_clear)         tx_overflow <= 1'b0;

      if (cpu_rx_rden && rx_empty) rx_underflow <= 1'b1;
      else if (err_clear)          rx_underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_port_ctrl.sv
// Scoreboard bench for serial_port_ctrl: stimulus queues expected bytes, negedge
// monitors pop and compare on every TX/RX handshake; directed checks cover flags and counts.
module tb_serial_port_ctrl;

  logic       clk, rst_n;
  logic [7:0] cpu_tx_data;
  logic       cpu_tx_wren, cpu_tx_ready;
  logic       cpu_rx_rden;
  logic [7:0] cpu_rx_data;
  logic       cpu_rx_valid;
  logic [7:0] uart_tx_data;
  logic       uart_tx_valid, uart_tx_ready;
  logic [7:0] uart_rx_data;
  logic       uart_rx_valid, uart_rx_ready;
  logic       err_clear, tx_overflow, rx_underflow;
  logic [4:0] tx_count, rx_count;

  serial_port_ctrl #(.TX_AW(4), .RX_AW(4), .TX_GAP(2)) dut (
    .clock        (clk),
    .reset        (rst_n),
    .cpu_tx_data  (cpu_tx_data),
    .cpu_tx_wren  (cpu_tx_wren),
    .cpu_tx_ready (cpu_tx_ready),
    .cpu_rx_rden  (cpu_rx_rden),
    .cpu_rx_data  (cpu_rx_data),
    .cpu_rx_valid (cpu_rx_valid),
    .uart_tx_data (uart_tx_data),
    .uart_tx_valid(uart_tx_valid),
    .uart_tx_ready(uart_tx_ready),
    .uart_rx_data (uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready),
    .err_clear    (err_clear),
    .tx_overflow  (tx_overflow),
    .rx_underflow (rx_underflow),
    .tx_count     (tx_count),
    .rx_count     (rx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int max_tx = 0;
  int max_rx = 0;
  logic stim_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitors: a handshake seen at negedge completes on the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (32'(tx_count) > max_tx) max_tx = 32'(tx_count);
      if (32'(rx_count) > max_rx) max_rx = 32'(rx_count);
      if (uart_tx_valid && uart_tx_ready) begin
        if (tx_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL tx_sb_unexpected: got byte 0x%0h, expected none", uart_tx_data);
        end else begin
          check("tx_sb_data", 32'(uart_tx_data), 32'(tx_q.pop_front()));
        end
      end
      if (cpu_rx_valid && cpu_rx_rden) begin
        if (rx_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rx_sb_unexpected: got byte 0x%0h, expected none", cpu_rx_data);
        end else begin
          check("rx_sb_data", 32'(cpu_rx_data), 32'(rx_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_valid [6];
    logic [7:0] exp_head [2];
    exp_valid = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_head  = '{8'h42, 8'h43};

    cpu_tx_data = '0; cpu_tx_wren = 0; cpu_rx_rden = 0;
    uart_tx_ready = 0; uart_rx_data = '0; uart_rx_valid = 0; err_clear = 0;
    stim_done = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Reset state
    @(negedge clk);
    check("rst_cpu_tx_ready",  32'(cpu_tx_ready), 1);
    check("rst_cpu_rx_valid",  32'(cpu_rx_valid), 0);
    check("rst_uart_tx_valid", 32'(uart_tx_valid), 0);
    check("rst_uart_rx_ready", 32'(uart_rx_ready), 1);
    check("rst_cpu_rx_data",   32'(cpu_rx_data), 0);
    check("rst_uart_tx_data",  32'(uart_tx_data), 0);
    check("rst_tx_count",      32'(tx_count), 0);
    check("rst_rx_count",      32'(rx_count), 0);
    check("rst_flags",         32'({tx_overflow, rx_underflow}), 0);
    tick();

    // T1: two bytes with gap pacing
    uart_tx_ready = 1;
    cpu_tx_wren = 1; cpu_tx_data = 8'h48; tx_q.push_back(8'h48);
    tick();
    cpu_tx_data = 8'h69; tx_q.push_back(8'h69);
    @(negedge clk);
    check("t1_valid_c1", 32'(uart_tx_valid), 1);
    check("t1_data_c1",  32'(uart_tx_data), 'h48);
    tick();
    cpu_tx_wren = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("t1_valid_c%0d", k + 2), 32'(uart_tx_valid), 32'(exp_valid[k]));
      tick();
    end
    check("t1_tx_count", 32'(tx_count), 0);
    check("t1_sb_empty", 32'(tx_q.size()), 0);

    // T2: stall and overflow
    uart_tx_ready = 0;
    for (int i = 0; i < 17; i++) begin
      if (i == 15) check("t2_ready_before_16th", 32'(cpu_tx_ready), 1);
      cpu_tx_wren = 1; cpu_tx_data = 8'(i);
      if (i < 16) tx_q.push_back(8'(i));
      tick();
    end
    cpu_tx_wren = 0;
    check("t2_cpu_tx_ready", 32'(cpu_tx_ready), 0);
    check("t2_tx_overflow",  32'(tx_overflow), 1);
    check("t2_tx_count",     32'(tx_count), 16);
    check("t2_valid_stall",  32'(uart_tx_valid), 1);
    check("t2_head_stall0",  32'(uart_tx_data), 0);
    repeat (3) tick();
    check("t2_head_stall3",  32'(uart_tx_data), 0);
    check("t2_count_stall3", 32'(tx_count), 16);
    uart_tx_ready = 1;
    for (int k = 0; k < 300 && !(tx_q.size() == 0 && tx_count == 0); k++) tick();
    check("t2_drain_count", 32'(tx_count), 0);
    check("t2_drain_sb",    32'(tx_q.size()), 0);

    // T3: RX FWFT and underflow
    for (int i = 0; i < 3; i++) begin
      uart_rx_valid = 1; uart_rx_data = 8'(8'h41 + i); rx_q.push_back(8'(8'h41 + i));
      tick();
    end
    uart_rx_valid = 0;
    check("t3_rx_valid", 32'(cpu_rx_valid), 1);
    check("t3_rx_head",  32'(cpu_rx_data), 'h41);
    check("t3_rx_count", 32'(rx_count), 3);
    for (int i = 0; i < 3; i++) begin
      cpu_rx_rden = 1;
      tick();
      cpu_rx_rden = 0;
      if (i < 2) check($sformatf("t3_head_after_pop%0d", i), 32'(cpu_rx_data), 32'(exp_head[i]));
    end
    check("t3_rx_valid_empty", 32'(cpu_rx_valid), 0);
    check("t3_rx_data_empty",  32'(cpu_rx_data), 0);
    cpu_rx_rden = 1;
    tick();
    cpu_rx_rden = 0;
    check("t3_rx_underflow",   32'(rx_underflow), 1);
    check("t3_rx_count_empty", 32'(rx_count), 0);

    // T4: full RX with simultaneous pop and push
    for (int i = 0; i < 16; i++) begin
      uart_rx_valid = 1; uart_rx_data = 8'(8'h80 + i); rx_q.push_back(8'(8'h80 + i));
      tick();
    end
    uart_rx_valid = 0;
    check("t4_rx_ready_full", 32'(uart_rx_ready), 0);
    check("t4_rx_count_full", 32'(rx_count), 16);
    cpu_rx_rden = 1; uart_rx_valid = 1; uart_rx_data = 8'hAA;
    tick();
    cpu_rx_rden = 0;
    check("t4_count_after_pop", 32'(rx_count), 15);
    check("t4_ready_after_pop", 32'(uart_rx_ready), 1);
    rx_q.push_back(8'hAA);
    tick();
    uart_rx_valid = 0;
    check("t4_count_after_push", 32'(rx_count), 16);
    for (int k = 0; k < 100 && !(rx_q.size() == 0 && rx_count == 0); k++) begin
      cpu_rx_rden = (rx_count != 0);
      tick();
    end
    cpu_rx_rden = 0;
    check("t4_drain_count", 32'(rx_count), 0);
    check("t4_drain_sb",    32'(rx_q.size()), 0);

    // T5: concurrent streams with random stalls (wrap-around)
    fork
      begin
        fork
          begin : tx_stim
            int ti, tg;
            ti = 0; tg = 0;
            while (ti < 40 && tg < 3000) begin
              if (cpu_tx_ready && $urandom_range(0, 3) != 0) begin
                cpu_tx_wren = 1; cpu_tx_data = 8'(ti * 3 + 16); tx_q.push_back(8'(ti * 3 + 16));
                ti++;
              end else cpu_tx_wren = 0;
              tick();
              tg++;
            end
            cpu_tx_wren = 0;
            check("t5_tx_sent", 32'(ti), 40);
          end
          begin : rx_stim
            int ri, rg;
            ri = 0; rg = 0;
            while (ri < 40 && rg < 3000) begin
              if (uart_rx_ready && $urandom_range(0, 3) != 0) begin
                uart_rx_valid = 1; uart_rx_data = 8'(ri * 5 + 7); rx_q.push_back(8'(ri * 5 + 7));
                ri++;
              end else uart_rx_valid = 0;
              tick();
              rg++;
            end
            uart_rx_valid = 0;
            check("t5_rx_sent", 32'(ri), 40);
          end
        join
        stim_done = 1;
      end
      begin : stall_gen
        while (!stim_done) begin
          uart_tx_ready = 1'($urandom_range(0, 1));
          cpu_rx_rden   = ($urandom_range(0, 2) != 0);
          tick();
        end
      end
    join
    uart_tx_ready = 1;
    for (int k = 0; k < 1000 && !(tx_q.size() == 0 && rx_q.size() == 0 && tx_count == 0 && rx_count == 0); k++) begin
      cpu_rx_rden = (rx_count != 0);
      tick();
    end
    cpu_rx_rden = 0;
    check("t5_tx_sb_empty", 32'(tx_q.size()), 0);
    check("t5_rx_sb_empty", 32'(rx_q.size()), 0);
    check("t5_tx_max_le16", 32'(max_tx <= 16), 1);
    check("t5_rx_max_le16", 32'(max_rx <= 16), 1);

    // T6: flag priority and clear
    check("t6_ovf_before", 32'(tx_overflow), 1);
    check("t6_udf_before", 32'(rx_underflow), 1);
    err_clear = 1; cpu_rx_rden = 1;
    tick();
    cpu_rx_rden = 0;
    check("t6_ovf_cleared",   32'(tx_overflow), 0);
    check("t6_udf_set_wins",  32'(rx_underflow), 1);
    tick();
    err_clear = 0;
    check("t6_udf_cleared", 32'(rx_underflow), 0);

    // T7: async reset mid-SEND discards buffered bytes
    uart_tx_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cpu_tx_wren = 1; cpu_tx_data = 8'(8'hE0 + i);
      uart_rx_valid = (i < 2); uart_rx_data = 8'(8'hD0 + i);
      tick();
    end
    cpu_tx_wren = 0; uart_rx_valid = 0;
    check("t7_tx_count_5", 32'(tx_count), 5);
    check("t7_valid_send", 32'(uart_tx_valid), 1);
    check("t7_rx_count_2", 32'(rx_count), 2);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("t7_valid_reset",    32'(uart_tx_valid), 0);
    check("t7_tx_count_reset", 32'(tx_count), 0);
    check("t7_rx_count_reset", 32'(rx_count), 0);
    check("t7_rx_valid_reset", 32'(cpu_rx_valid), 0);
    check("t7_tx_ready_reset", 32'(cpu_tx_ready), 1);
    tick();
    rst_n = 1;
    tick();
    check("t7_valid_after_release", 32'(uart_tx_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
